// File: rtl/pbtn_event_pkg.sv
// Shared register map, field widths and repeat FSM encoding for the pushbutton event block.
// Pure definitions: no latency, no flow control.
package pbtn_event_pkg;

    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_ENABLE  = 2'd2;
    localparam logic [1:0] ADDR_CONFIG  = 2'd3;

    localparam int NUM_PB      = 6;
    localparam int NUM_SW      = 16;
    localparam int PEND_SW_LSB = 6;
    localparam int PEND_W      = PEND_SW_LSB + NUM_SW;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/pbtn_event_ctrl_if.sv
// Four-word register port between the GPIO bus wrapper (master) and the event block (slave).
// Strobes are single-cycle; the slave always acknowledges on the following cycle, no stalls.
interface pbtn_event_ctrl_if;

    logic [1:0]  reg_addr;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    modport master (
        output reg_addr, reg_wr, reg_rd, reg_wdata,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_addr, reg_wr, reg_rd, reg_wdata,
        output reg_rdata, reg_ack
    );

endinterface

// File: rtl/pbtn_repeat_fsm.sv
// Typematic auto-repeat for one button: rpt pulses combinationally on the tick that exhausts the count.
// No backpressure; releasing the button or clearing en returns to IDLE immediately.
module pbtn_repeat_fsm
    import pbtn_event_pkg::*;
#(
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic level,
    input  logic press,
    input  logic tick,
    output logic rpt
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    rpt_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RPT_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpt     = 1'b0;
        if (!en || !level) begin
            state_d = RPT_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RPT_IDLE: begin
                    if (press) begin
                        state_d = RPT_DELAY;
                        cnt_d   = DELAY_C;
                    end
                end
                RPT_DELAY, RPT_REPEAT: begin
                    // Reaching zero on this tick fires and reloads with the repeat period.
                    if (tick) begin
                        if (cnt_q <= ONE_C) begin
                            rpt     = 1'b1;
                            state_d = RPT_REPEAT;
                            cnt_d   = RATE_C;
                        end else begin
                            cnt_d = cnt_q - ONE_C;
                        end
                    end
                end
                default: begin
                    state_d = RPT_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pbtn_event_ctrl.sv
// Debounced buttons/switches -> W1C pending events (press, auto-repeat, switch change) -> level irq.
// Register reads/writes acknowledge one cycle after the strobe; events are never dropped or stalled.
module pbtn_event_ctrl
    import pbtn_event_pkg::*;
#(
    parameter int CLK_FREQUENCY_HZ = 100_000_000,
    parameter int TICK_HZ          = 1000,
    parameter int TICK_DIV         = CLK_FREQUENCY_HZ / TICK_HZ,
    parameter bit PB0_ACTIVE_LOW   = 1'b1,
    parameter int REPEAT_DELAY     = 500,
    parameter int REPEAT_RATE      = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_PB-1:0] pbtn_db,
    input  logic [NUM_SW-1:0] swtch_db,
    pbtn_event_ctrl_if.slave  bus,
    output logic              irq
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              primed_q, primed_d;
    logic [NUM_PB-1:0] prev_b_q, prev_b_d;
    logic [NUM_SW-1:0] prev_s_q, prev_s_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [PEND_W-1:0] enable_q, enable_d;
    logic [NUM_PB-1:0] config_q, config_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              irq_q, irq_d;

    logic              tick;
    logic [NUM_PB-1:0] b;
    logic [NUM_PB-1:0] press;
    logic [NUM_PB-1:0] rpt;
    logic [NUM_SW-1:0] change;
    logic [PEND_W-1:0] events;
    logic [PEND_W-1:0] w1c_mask;
    logic [31:0]       rd_val;
    logic              unused_wdata;

    assign unused_wdata = ^bus.reg_wdata[31:PEND_W];

    assign b    = pbtn_db ^ {{(NUM_PB-1){1'b0}}, PB0_ACTIVE_LOW};
    assign tick = (tick_cnt_q == TICK_LAST);

    // Until primed, prev_* hold reset values, so any edge seen then would be spurious.
    assign press  = primed_q ? (b & ~prev_b_q) : '0;
    assign change = primed_q ? (swtch_db ^ prev_s_q) : '0;

    for (genvar i = 0; i < NUM_PB; i++) begin : g_rpt
        pbtn_repeat_fsm #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_fsm (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (config_q[i]),
            .level (b[i]),
            .press (press[i]),
            .tick  (tick),
            .rpt   (rpt[i])
        );
    end

    assign events = {change, press | rpt};

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        primed_d   = 1'b1;
        prev_b_d   = b;
        prev_s_d   = swtch_db;

        w1c_mask = '0;
        enable_d = enable_q;
        config_d = config_q;
        if (bus.reg_wr) begin
            case (bus.reg_addr)
                ADDR_PENDING: w1c_mask = bus.reg_wdata[PEND_W-1:0];
                ADDR_ENABLE:  enable_d = bus.reg_wdata[PEND_W-1:0];
                ADDR_CONFIG:  config_d = bus.reg_wdata[NUM_PB-1:0];
                default:      w1c_mask = '0;
            endcase
        end
        // New events are OR'd in after the clear, so a same-cycle set survives the W1C.
        pend_d = (pend_q & ~w1c_mask) | events;

        case (bus.reg_addr)
            ADDR_STATUS:  rd_val = {swtch_db, 10'b0, prev_b_q};
            ADDR_PENDING: rd_val = 32'(pend_q);
            ADDR_ENABLE:  rd_val = 32'(enable_q);
            ADDR_CONFIG:  rd_val = 32'(config_q);
            default:      rd_val = '0;
        endcase
        rdata_d = bus.reg_rd ? rd_val : '0;
        ack_d   = bus.reg_rd | bus.reg_wr;
        irq_d   = |(pend_d & enable_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            primed_q   <= 1'b0;
            prev_b_q   <= '0;
            prev_s_q   <= '0;
            pend_q     <= '0;
            enable_q   <= '0;
            config_q   <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            primed_q   <= primed_d;
            prev_b_q   <= prev_b_d;
            prev_s_q   <= prev_s_d;
            pend_q     <= pend_d;
            enable_q   <= enable_d;
            config_q   <= config_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.reg_rdata = rdata_q;
    assign bus.reg_ack   = ack_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_pbtn_event_ctrl.sv
// Bench for pbtn_event_ctrl: register traffic is scored by a monitor popping expected read data on reg_ack.
module tb_pbtn_event_ctrl;
    import pbtn_event_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  pbtn_db = 6'b000001;
    logic [15:0] swtch_db = 16'h0081;
    logic        irq;

    pbtn_event_ctrl_if bus();

    pbtn_event_ctrl #(
        .CLK_FREQUENCY_HZ (100_000_000),
        .TICK_HZ          (1000),
        .TICK_DIV         (4),
        .PB0_ACTIVE_LOW   (1'b1),
        .REPEAT_DELAY     (3),
        .REPEAT_RATE      (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pbtn_db  (pbtn_db),
        .swtch_db (swtch_db),
        .bus      (bus),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];
    string       name_q[$];
    logic        strobe_prev = 1'b0;
    int          edges = 0;

    always @(posedge clk) begin
        strobe_prev <= rst_n && (bus.reg_rd || bus.reg_wr);
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    // Monitor: ack must follow each strobe by exactly one cycle; reads are compared in issue order.
    always @(negedge clk) begin
        logic [32:0] e;
        string       n;
        if (strobe_prev || bus.reg_ack) begin
            total++;
            if (bus.reg_ack !== strobe_prev) begin
                bad++;
                $display("FAIL ack_timing: ack=%0b required=%0b at %0t", bus.reg_ack, strobe_prev, $time);
            end
        end
        if (bus.reg_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: no outstanding access at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (e[32]) begin
                    total++;
                    if (bus.reg_rdata !== e[31:0]) begin
                        bad++;
                        $display("FAIL %s: rdata=%h required=%h at %0t", n, bus.reg_rdata, e[31:0], $time);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic bus_op(input logic rd, input logic wr, input logic [1:0] a,
                          input logic [31:0] wd, input logic [31:0] req, input string nm);
        bus.reg_rd    = rd;
        bus.reg_wr    = wr;
        bus.reg_addr  = a;
        bus.reg_wdata = wd;
        exp_q.push_back({rd, req});
        name_q.push_back(nm);
        step();
        bus.reg_rd = 1'b0;
        bus.reg_wr = 1'b0;
    endtask

    // Next edge lands one cycle after a tick (ticks at edge indices 3, 7, 11, ...).
    task automatic align();
        while (edges % 4 != 0) step();
    endtask

    initial begin
        logic [31:0] req;
        bus.reg_rd    = 1'b0;
        bus.reg_wr    = 1'b0;
        bus.reg_addr  = 2'd0;
        bus.reg_wdata = 32'd0;

        // 1: reset state, priming with a switch already on and pb0 idle-high
        step();
        step();
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ack", {31'd0, bus.reg_ack}, 32'd0);
        check("rst_rdata", bus.reg_rdata, 32'd0);
        rst_n = 1'b1;
        step();
        step();
        check("prime_irq", {31'd0, irq}, 32'd0);
        bus_op(1, 0, ADDR_PENDING, 0, 32'h0, "prime_pending");
        bus_op(1, 0, ADDR_STATUS, 0, 32'h0081_0000, "status_reset");
        bus_op(1, 0, ADDR_CONFIG, 0, 32'h0, "config_reset");

        // 2: press -> pending -> irq; W1C clears both
        bus_op(0, 1, ADDR_ENABLE, 32'h4, 0, "");
        bus_op(1, 0, ADDR_ENABLE, 0, 32'h4, "enable_rb");
        pbtn_db[2] = 1'b1;
        check("irq_before", {31'd0, irq}, 32'd0);
        step();
        check("irq_rise", {31'd0, irq}, 32'd1);
        bus_op(1, 0, ADDR_PENDING, 0, 32'h4, "pend_press");
        bus_op(0, 1, ADDR_PENDING, 32'h4, 0, "");
        check("irq_cleared", {31'd0, irq}, 32'd0);
        pbtn_db[2] = 1'b0;
        step();
        bus_op(1, 0, ADDR_PENDING, 0, 32'h0, "pend_release");

        // 3: auto-repeat on pb1, observed with a read-and-clear every cycle
        bus_op(0, 1, ADDR_CONFIG, 32'h2, 0, "");
        bus_op(0, 1, ADDR_PENDING, 32'h003F_FFFF, 0, "");
        align();
        pbtn_db[1] = 1'b1;
        for (int k = 0; k < 32; k++) begin
            if (k == 30) pbtn_db[1] = 1'b0;
            req = (k == 1 || k == 12 || k == 20 || k == 28) ? 32'h2 : 32'h0;
            bus_op(1, 1, ADDR_PENDING, 32'h2, req, "rpt_hold");
        end
        align();
        pbtn_db[1] = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k == 8) pbtn_db[1] = 1'b0;
            req = (k == 1) ? 32'h2 : 32'h0;
            bus_op(1, 1, ADDR_PENDING, 32'h2, req, "rpt_early_release");
        end

        // 4: switch change events both directions, STATUS reflects live switches
        swtch_db[15] = 1'b1;
        step();
        check("sw_irq_masked", {31'd0, irq}, 32'd0);
        bus_op(1, 0, ADDR_PENDING, 0, 32'h0020_0000, "sw_rise");
        bus_op(0, 1, ADDR_PENDING, 32'h0020_0000, 0, "");
        bus_op(1, 0, ADDR_STATUS, 0, 32'h8081_0000, "status_sw");
        swtch_db[15] = 1'b0;
        step();
        bus_op(1, 0, ADDR_PENDING, 0, 32'h0020_0000, "sw_fall");
        bus_op(0, 1, ADDR_PENDING, 32'h0020_0000, 0, "");

        // 5: set wins over a same-cycle W1C
        pbtn_db[3] = 1'b1;
        step();
        pbtn_db[3] = 1'b0;
        step();
        bus_op(1, 0, ADDR_PENDING, 0, 32'h8, "pb3_pend");
        pbtn_db[3] = 1'b1;
        bus_op(0, 1, ADDR_PENDING, 32'h8, 0, "");
        bus_op(1, 0, ADDR_PENDING, 0, 32'h8, "set_wins");
        bus_op(1, 0, ADDR_STATUS, 0, 32'h0081_0008, "status_pb3");
        pbtn_db[3] = 1'b0;
        bus_op(0, 1, ADDR_PENDING, 32'h8, 0, "");
        bus_op(1, 0, ADDR_PENDING, 0, 32'h0, "w1c_plain");

        // 6: reset while repeating with pending set; held button must stay silent afterwards
        bus_op(0, 1, ADDR_ENABLE, 32'h003F_FFFF, 0, "");
        align();
        pbtn_db[1] = 1'b1;
        for (int k = 0; k < 14; k++) step();
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        rst_n = 1'b0;
        step();
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        check("mid_rst_ack", {31'd0, bus.reg_ack}, 32'd0);
        check("mid_rst_rdata", bus.reg_rdata, 32'd0);
        rst_n = 1'b1;
        step();
        step();
        step();
        bus_op(1, 0, ADDR_PENDING, 0, 32'h0, "post_rst_pend");
        bus_op(1, 0, ADDR_ENABLE, 0, 32'h0, "post_rst_enable");
        bus_op(1, 0, ADDR_CONFIG, 0, 32'h0, "post_rst_config");
        bus_op(0, 1, ADDR_CONFIG, 32'h2, 0, "");
        for (int k = 0; k < 16; k++) step();
        bus_op(1, 0, ADDR_PENDING, 0, 32'h0, "held_no_event");
        check("post_rst_irq", {31'd0, irq}, 32'd0);
        pbtn_db[1] = 1'b0;
        step();
        step();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL outstanding: left=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
